// File: rtl/regfile_pair_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pair_if : decode / write-back bus of the paired register file
// Revision 1.0
// ---------------------------------------------------------------------------
interface regfile_pair_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                  rd_en;
  logic [ADDR_W-1:0]     rs1_addr;
  logic                  rs1_pair;
  logic [ADDR_W-1:0]     rs2_addr;
  logic [2*DATA_W-1:0]   rs1_data;
  logic [DATA_W-1:0]     rs2_data;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  we;
  logic [ADDR_W-1:0]     wr_addr;
  logic                  wr_pair;
  logic [2*DATA_W-1:0]   wr_data;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic                  sb_pair;

  modport master (
    output rd_en, rs1_addr, rs1_pair, rs2_addr,
    output we, wr_addr, wr_pair, wr_data,
    output sb_set, sb_addr, sb_pair,
    input  rs1_data, rs2_data, rs1_busy, rs2_busy
  );

  modport slave (
    input  rd_en, rs1_addr, rs1_pair, rs2_addr,
    input  we, wr_addr, wr_pair, wr_data,
    input  sb_set, sb_addr, sb_pair,
    output rs1_data, rs2_data, rs1_busy, rs2_busy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_pair.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_pair : 2R/1W register file with pair access and busy scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module regfile_pair #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic           clk,
  input  logic           reset,
  regfile_pair_if.slave  bus
);
  localparam int c_NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0]  w_cur     [c_NREGS];
  logic [DATA_W-1:0]  w_nxt     [c_NREGS];
  logic [DATA_W-1:0]  w_rd_val  [c_NREGS];
  logic [c_NREGS-1:0] w_busy_cur;
  logic [c_NREGS-1:0] w_busy_nxt;
  logic [c_NREGS-1:0] w_rd_busy;
  logic [c_NREGS-1:0] w_wr_hit;
  logic [c_NREGS-1:0] w_sb_hit;

  logic [ADDR_W-1:0]  w_wr_addr_p1;
  logic [ADDR_W-1:0]  w_sb_addr_p1;
  logic [ADDR_W-1:0]  w_rs1_addr_p1;

  logic [2*DATA_W-1:0] r_rs1_data;
  logic [DATA_W-1:0]   r_rs2_data;
  logic                r_rs1_busy;
  logic                r_rs2_busy;

  // Pair partners wrap modulo NREGS through natural address overflow
  assign w_wr_addr_p1  = bus.wr_addr  + 1'b1;
  assign w_sb_addr_p1  = bus.sb_addr  + 1'b1;
  assign w_rs1_addr_p1 = bus.rs1_addr + 1'b1;

  for (genvar i = 0; i < c_NREGS; i++) begin : g_reg
    localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(i);

    if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
      assign w_wr_hit[i]   = 1'b0;
      assign w_sb_hit[i]   = 1'b0;
      assign w_cur[i]      = '0;
      assign w_nxt[i]      = '0;
      assign w_busy_cur[i] = 1'b0;
      assign w_busy_nxt[i] = 1'b0;
    end else begin : g_live
      logic [DATA_W-1:0] r_val;
      logic              r_busy;

      assign w_wr_hit[i] = bus.we &&
          ((bus.wr_addr == c_IDX) || (bus.wr_pair && (w_wr_addr_p1 == c_IDX)));
      assign w_sb_hit[i] = bus.sb_set &&
          ((bus.sb_addr == c_IDX) || (bus.sb_pair && (w_sb_addr_p1 == c_IDX)));

      // Pair writes put the high half at wr_addr, the low half at wr_addr+1
      assign w_nxt[i] = !w_wr_hit[i] ? r_val :
          (bus.wr_pair && (bus.wr_addr == c_IDX)) ? bus.wr_data[2*DATA_W-1:DATA_W]
                                                  : bus.wr_data[DATA_W-1:0];
      // A new producer issued in the same cycle outranks the retiring write
      assign w_busy_nxt[i] = w_sb_hit[i] | (r_busy & ~w_wr_hit[i]);
      assign w_cur[i]      = r_val;
      assign w_busy_cur[i] = r_busy;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_val  <= '0;
          r_busy <= 1'b0;
        end else begin
          r_val  <= w_nxt[i];
          r_busy <= w_busy_nxt[i];
        end
      end
    end
  end

  if (BYPASS != 0) begin : g_bypass
    assign w_rd_val  = w_nxt;
    assign w_rd_busy = w_busy_nxt;
  end else begin : g_no_bypass
    assign w_rd_val  = w_cur;
    assign w_rd_busy = w_busy_cur;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_rs1_busy <= 1'b0;
      r_rs2_busy <= 1'b0;
    end else if (bus.rd_en) begin
      r_rs1_data <= bus.rs1_pair
          ? {w_rd_val[bus.rs1_addr], w_rd_val[w_rs1_addr_p1]}
          : {{DATA_W{1'b0}}, w_rd_val[bus.rs1_addr]};
      r_rs1_busy <= w_rd_busy[bus.rs1_addr] | (bus.rs1_pair & w_rd_busy[w_rs1_addr_p1]);
      r_rs2_data <= w_rd_val[bus.rs2_addr];
      r_rs2_busy <= w_rd_busy[bus.rs2_addr];
    end
  end

  assign bus.rs1_data = r_rs1_data;
  assign bus.rs2_data = r_rs2_data;
  assign bus.rs1_busy = r_rs1_busy;
  assign bus.rs2_busy = r_rs2_busy;

endmodule
`default_nettype wire

// File: doc/regfile_pair.md
# regfile_pair

Parametrised, fully synchronous register file for the 8-bit datapath. It has two read ports with registered outputs and one write port that accepts single-register or register-pair (double-width) writes. A per-register busy scoreboard lets decode detect read-after-write hazards. It sits between decode (addresses, scoreboard set) and write-back (write port) and replaces the combinational register bank.

## Interface
Parameters:
- DATA_W, 8, width of one register
- ADDR_W, 3, address width; NREGS = 2**ADDR_W registers
- BYPASS, 1, 1 = a same-cycle write is forwarded to the read outputs; 0 = reads return pre-write contents
- ZERO_REG, 0, 1 = register 0 is hard-wired to zero, never written, never busy

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- rd_en  in  1  capture a read on both ports this cycle
- rs1_addr  in  ADDR_W  port-1 address
- rs1_pair  in  1  1 = port 1 reads pair {reg[rs1_addr], reg[rs1_addr+1]}
- rs2_addr  in  ADDR_W  port-2 address (single register only)
- rs1_data  out  2*DATA_W  registered port-1 data; upper DATA_W bits are zero when rs1_pair=0
- rs2_data  out  DATA_W  registered port-2 data
- rs1_busy  out  1  registered OR of the busy bits of every register read on port 1
- rs2_busy  out  1  registered busy bit of rs2_addr
- we  in  1  write enable
- wr_addr  in  ADDR_W  destination register
- wr_pair  in  1  1 = wr_data[2*DATA_W-1:DATA_W] goes to wr_addr and wr_data[DATA_W-1:0] goes to wr_addr+1
- wr_data  in  2*DATA_W  write data; a single write uses the low DATA_W bits
- sb_set  in  1  mark destination register(s) busy
- sb_addr  in  ADDR_W  scoreboard destination
- sb_pair  in  1  1 = mark sb_addr and sb_addr+1

## Operation
- Storage is NREGS x DATA_W flops. There are no initial-file loads.
- Pair addressing: "addr+1" is computed modulo NREGS. A pair at NREGS-1 wraps to register 0.
- Write (we=1): target register(s) update at the clock edge. The busy bit of each written register clears at the same edge.
- With ZERO_REG=1, any write half aimed at register 0 is dropped. In a pair write the other half is still written. Register 0 always reads 0 and its busy bit stays 0.
- Scoreboard set (sb_set=1): the busy bit(s) of sb_addr (and sb_addr+1 if sb_pair) set at the edge.
- Set and clear on the same register in the same cycle: set wins, because a new producer was issued.
- Read (rd_en=1): rs1_data, rs2_data, rs1_busy and rs2_busy load at the edge. With rd_en=0 they hold their values.
- BYPASS=1: if a write this cycle hits a register being read, the read captures the new wr_data half for that register. The busy output then reflects the post-edge busy bit (cleared unless re-set in the same cycle). This forwarding applies per half for pair reads.
- BYPASS=0: reads capture the pre-edge register contents and busy bits.
- Both read ports may address the same register, and may overlap the write port. The ports are independent.

## Timing
- Read latency is 1 cycle: addresses and rd_en are presented in cycle N, data is valid after edge N, through cycle N+1.
- Write latency is 1 cycle: a write in cycle N is visible to a non-bypassed read in cycle N+1.
- Reset (synchronous, dominant): at the edge with reset=1, all registers become 0, all busy bits become 0, rs1_data=0, rs2_data=0, rs1_busy=0 and rs2_busy=0.
- Any we, sb_set or rd_en in a reset cycle is ignored. This includes a reset asserted mid-sequence, for example between the set and the clear of a busy bit.
- No combinational path exists from any input to any output.

## Test plan
- Reset, then write 8'hA5 to r3 (single) and read r3 on both ports -> after 1 cycle rs1_data=16'h00A5, rs2_data=8'hA5, both busy flags 0.
- Pair write 16'h1234 at r7 with NREGS=8, then a pair read at r7 -> r7=8'h12, r0=8'h34, rs1_data=16'h1234 (wrap verified).
- Set busy on r2, then read r2 -> rs2_busy=1. Next, write r2=8'h5A while reading r2 in the same cycle with BYPASS=1 -> rs2_data=8'h5A, rs2_busy=0. Repeat with BYPASS=0 -> old data returned, busy=1.
- In the same cycle, set busy on r4 and write r4=8'h77 -> r4=8'h77 and its busy bit stays 1 (set wins).
- ZERO_REG=1: pair write 16'hBEEF at r7 -> r7=8'hBE, r0 reads 0, and a single write of 8'hFF to r0 has no effect.
- Load all registers and busy bits, then assert reset for 1 cycle during a write to r5 -> all registers read 0, all outputs 0, and r5 is not written.
